// File: rtl/mcu_bus_window_writer_if.sv
// MCU 8080-style bus pins plus the x/y-addressed pixel stream, bundled for mcu_bus_window_writer.
// Latency: none (wiring only).
// Backpressure: pix_ready from the consumer side (master modport) throttles pix_valid.
// Ports: mcu_cs_n/mcu_rs/mcu_wr_n/mcu_rd_n/mcu_data_in from the MCU; mcu_data_out/mcu_data_oe back to it;
//        pix_valid/pix_data/pix_x/pix_y/pix_sof out to the frame-buffer writer, pix_ready back in.
interface mcu_bus_window_writer_if #(
    parameter int DW = 16,
    parameter int XW = 10,
    parameter int YW = 9
);
    logic          mcu_cs_n;
    logic          mcu_rs;
    logic          mcu_wr_n;
    logic          mcu_rd_n;
    logic [DW-1:0] mcu_data_in;
    logic [DW-1:0] mcu_data_out;
    logic          mcu_data_oe;

    logic          pix_valid;
    logic          pix_ready;
    logic [DW-1:0] pix_data;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          pix_sof;

    // Slave: the bus decoder / pixel source.
    modport slave (
        input  mcu_cs_n, mcu_rs, mcu_wr_n, mcu_rd_n, mcu_data_in,
        output mcu_data_out, mcu_data_oe,
        output pix_valid, pix_data, pix_x, pix_y, pix_sof,
        input  pix_ready
    );

    // Master: the MCU driving the bus and the pixel consumer.
    modport master (
        output mcu_cs_n, mcu_rs, mcu_wr_n, mcu_rd_n, mcu_data_in,
        input  mcu_data_out, mcu_data_oe,
        input  pix_valid, pix_data, pix_x, pix_y, pix_sof,
        output pix_ready
    );
endinterface

// File: rtl/mcu_bus_window_writer.sv
// 8080-style MCU bus slave: RS=0 selects a command, RS=1 loads window/PWM registers or streams pixels.
// Latency: SYNC_STAGES+1 clk from WR rise to commit; pixel beat presented the clock after commit.
// Backpressure: single-entry output register; a pixel arriving while it is full and not draining is dropped (sticky overflow).
// Ports: clk, rst (async, active-high); bus (mcu_bus_window_writer_if.slave): MCU pins and pixel stream;
//        pwm_duty: backlight duty register; overflow: sticky pixel-dropped flag.
// Build option: define MCU_READBACK_EN to enable RD readback of the selected register on mcu_data_out/mcu_data_oe.
module mcu_bus_window_writer #(
    parameter int DW          = 16,
    parameter int XW          = 10,
    parameter int YW          = 9,
    parameter int H_MAX       = 800,
    parameter int V_MAX       = 480,
    parameter int SYNC_STAGES = 2,
    parameter int PWM_BITS    = 4
) (
    input  logic                clk,
    input  logic                rst,
    mcu_bus_window_writer_if.slave bus,
    output logic [PWM_BITS-1:0] pwm_duty,
    output logic                overflow
);

    localparam logic [7:0] CMD_PWM    = 8'h01;
    localparam logic [7:0] CMD_ROW_S  = 8'h02;
    localparam logic [7:0] CMD_COL_S  = 8'h03;
    localparam logic [7:0] CMD_ROW_E  = 8'h06;
    localparam logic [7:0] CMD_COL_E  = 8'h07;
    localparam logic [7:0] CMD_STREAM = 8'h0F;
    localparam logic [7:0] CMD_STATUS = 8'h10;

    localparam logic [XW-1:0] COL_LAST = XW'(H_MAX - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(V_MAX - 1);

    typedef enum logic {ST_CFG, ST_STREAM} state_t;
    state_t state_q, state_d;

    // ---------------- input synchronisers ----------------
    logic [SYNC_STAGES-1:0] cs_sr, rs_sr, wr_sr;
    logic [DW-1:0]          dat_sr [SYNC_STAGES];
    logic                   cs_s, rs_s, wr_s;
    logic [DW-1:0]          dat_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sr <= '1;
            rs_sr <= '0;
            wr_sr <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) dat_sr[i] <= '0;
        end else begin
            cs_sr     <= {cs_sr[SYNC_STAGES-2:0], bus.mcu_cs_n};
            rs_sr     <= {rs_sr[SYNC_STAGES-2:0], bus.mcu_rs};
            wr_sr     <= {wr_sr[SYNC_STAGES-2:0], bus.mcu_wr_n};
            dat_sr[0] <= bus.mcu_data_in;
            for (int i = 1; i < SYNC_STAGES; i++) dat_sr[i] <= dat_sr[i-1];
        end
    end

    assign cs_s  = cs_sr[SYNC_STAGES-1];
    assign rs_s  = rs_sr[SYNC_STAGES-1];
    assign wr_s  = wr_sr[SYNC_STAGES-1];
    assign dat_s = dat_sr[SYNC_STAGES-1];

    // ---------------- write strobe decode ----------------
    // RS/data/CS are latched while synced WR is low, so the commit on the
    // rising edge uses the values from the last low cycle.
    logic          wr_q, lat_cs, lat_rs;
    logic [DW-1:0] lat_dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= 1'b1;
            lat_cs  <= 1'b1;
            lat_rs  <= 1'b0;
            lat_dat <= '0;
        end else begin
            wr_q <= wr_s;
            if (!wr_s) begin
                lat_cs  <= cs_s;
                lat_rs  <= rs_s;
                lat_dat <= dat_s;
            end
        end
    end

    logic commit, cmd_wr, reg_wr, pix_wr;
    assign commit = !wr_q && wr_s && !cs_s && !lat_cs;
    assign cmd_wr = commit && !lat_rs;
    assign reg_wr = commit && lat_rs && (state_q == ST_CFG);
    assign pix_wr = commit && lat_rs && (state_q == ST_STREAM);

    // ---------------- streaming FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_CFG;
        else     state_q <= state_d;
    end

    // Any command write leaves streaming; only 0x0F (re)enters it.
    always_comb begin
        state_d = state_q;
        if (cmd_wr) state_d = (lat_dat[7:0] == CMD_STREAM) ? ST_STREAM : ST_CFG;
    end

    // ---------------- configuration registers ----------------
    logic [7:0]    cmd;
    logic [XW-1:0] col_s, col_e, col_in;
    logic [YW-1:0] row_s, row_e, row_in;

    assign col_in = (lat_dat > DW'(H_MAX - 1)) ? COL_LAST : lat_dat[XW-1:0];
    assign row_in = (lat_dat > DW'(V_MAX - 1)) ? ROW_LAST : lat_dat[YW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd      <= '0;
            pwm_duty <= '0;
            col_s    <= '0;
            row_s    <= '0;
            col_e    <= COL_LAST;
            row_e    <= ROW_LAST;
        end else if (cmd_wr) begin
            cmd <= lat_dat[7:0];
        end else if (reg_wr) begin
            case (cmd)
                CMD_PWM:   pwm_duty <= lat_dat[PWM_BITS-1:0];
                CMD_ROW_S: row_s    <= row_in;
                CMD_COL_S: col_s    <= col_in;
                CMD_ROW_E: row_e    <= row_in;
                CMD_COL_E: col_e    <= col_in;
                default:   ;
            endcase
        end
    end

    // ---------------- active window, cursor, output register ----------------
    // The window is snapshotted at 0x0F so bound edits made later only apply
    // to the next stream; start>end collapses to a single row/column.
    logic [XW-1:0] win_cs, win_ce, cur_x, pix_x_q;
    logic [YW-1:0] win_rs, win_re, cur_y, pix_y_q;
    logic [DW-1:0] pix_data_q;
    logic          sof_pend, pix_valid_q, pix_sof_q, can_load;

    assign can_load = !pix_valid_q || bus.pix_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cs      <= '0;
            win_ce      <= COL_LAST;
            win_rs      <= '0;
            win_re      <= ROW_LAST;
            cur_x       <= '0;
            cur_y       <= '0;
            sof_pend    <= 1'b0;
            overflow    <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_sof_q   <= 1'b0;
            pix_data_q  <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
        end else begin
            if (cmd_wr && lat_dat[7:0] == CMD_STREAM) begin
                win_cs   <= col_s;
                win_ce   <= (col_e > col_s) ? col_e : col_s;
                win_rs   <= row_s;
                win_re   <= (row_e > row_s) ? row_e : row_s;
                cur_x    <= col_s;
                cur_y    <= row_s;
                sof_pend <= 1'b1;
            end
            if (cmd_wr && lat_dat[7:0] == CMD_STATUS) overflow <= 1'b0;

            if (pix_wr) begin
                if (can_load) begin
                    pix_valid_q <= 1'b1;
                    pix_data_q  <= lat_dat;
                    pix_x_q     <= cur_x;
                    pix_y_q     <= cur_y;
                    pix_sof_q   <= sof_pend;
                end else begin
                    overflow <= 1'b1;
                end
                // Cursor advances even for a dropped pixel so the image stays aligned.
                sof_pend <= 1'b0;
                if (cur_x == win_ce) begin
                    cur_x <= win_cs;
                    if (cur_y == win_re) begin
                        cur_y    <= win_rs;
                        sof_pend <= 1'b1;
                    end else begin
                        cur_y <= cur_y + 1'b1;
                    end
                end else begin
                    cur_x <= cur_x + 1'b1;
                end
            end else if (pix_valid_q && bus.pix_ready) begin
                pix_valid_q <= 1'b0;
            end
        end
    end

    assign bus.pix_valid = pix_valid_q;
    assign bus.pix_data  = pix_data_q;
    assign bus.pix_x     = pix_x_q;
    assign bus.pix_y     = pix_y_q;
    assign bus.pix_sof   = pix_sof_q;

    // ---------------- optional readback ----------------
`ifdef MCU_READBACK_EN
    logic [SYNC_STAGES-1:0] rd_sr;
    logic                   rd_s, rd_active, oe_q;
    logic [DW-1:0]          rb_sel, out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_sr <= '1;
        else     rd_sr <= {rd_sr[SYNC_STAGES-2:0], bus.mcu_rd_n};
    end
    assign rd_s = rd_sr[SYNC_STAGES-1];

    // WR low has priority over RD: never drive the bus during a write.
    assign rd_active = !cs_s && !rd_s && rs_s && wr_s;

    always_comb begin
        rb_sel = '0;
        case (cmd)
            CMD_PWM:    rb_sel = DW'(pwm_duty);
            CMD_ROW_S:  rb_sel = DW'(row_s);
            CMD_COL_S:  rb_sel = DW'(col_s);
            CMD_ROW_E:  rb_sel = DW'(row_e);
            CMD_COL_E:  rb_sel = DW'(col_e);
            CMD_STATUS: rb_sel = DW'({overflow, state_q == ST_STREAM});
            default:    rb_sel = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oe_q  <= 1'b0;
            out_q <= '0;
        end else begin
            oe_q  <= rd_active;
            out_q <= rd_active ? rb_sel : '0;
        end
    end

    assign bus.mcu_data_oe  = oe_q;
    assign bus.mcu_data_out = out_q;
`else
    assign bus.mcu_data_oe  = 1'b0;
    assign bus.mcu_data_out = '0;
`endif

endmodule

// File: tb/tb_mcu_bus_window_writer.sv
// Directed bench for mcu_bus_window_writer: register loads, window scan, backpressure/overflow,
// clamping/collapsed window, reset mid-stream and readback (build dependent).
module tb_mcu_bus_window_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [3:0] pwm_duty;
    logic       overflow;

    mcu_bus_window_writer_if #(.DW(16), .XW(10), .YW(9)) bus ();

    mcu_bus_window_writer dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .pwm_duty (pwm_duty),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [9:0]  x;
        logic [8:0]  y;
        logic        sof;
    } beat_t;
    beat_t beats[$];

    // A beat seen valid&&ready at the falling edge transfers on the next rising edge.
    always @(negedge clk) begin
        if (!rst && bus.pix_valid && bus.pix_ready)
            beats.push_back('{bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_sof});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mcu_write(input logic rs, input logic [15:0] d);
        @(negedge clk);
        bus.mcu_cs_n    = 1'b0;
        bus.mcu_rs      = rs;
        bus.mcu_data_in = d;
        bus.mcu_wr_n    = 1'b0;
        repeat (4) @(negedge clk);
        bus.mcu_wr_n = 1'b1;
        repeat (4) @(negedge clk);
        bus.mcu_cs_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain_one();
        @(negedge clk);
        bus.pix_ready = 1'b1;
        @(negedge clk);
        bus.pix_ready = 1'b0;
    endtask

    initial begin
        bus.mcu_cs_n    = 1'b1;
        bus.mcu_rs      = 1'b0;
        bus.mcu_wr_n    = 1'b1;
        bus.mcu_rd_n    = 1'b1;
        bus.mcu_data_in = '0;
        bus.pix_ready   = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_valid", bus.pix_valid, 0);
        check("rst_pwm", pwm_duty, 0);
        check("rst_ovf", overflow, 0);
        check("rst_oe", bus.mcu_data_oe, 0);
        check("rst_dout", bus.mcu_data_out, 0);
        check("rst_xy", {bus.pix_x, bus.pix_y}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // ---- 1: PWM load ----
        mcu_write(1'b0, 16'h0001);
        mcu_write(1'b1, 16'h0002);
        check("pwm_load", pwm_duty, 2);
        check("pwm_no_pix", bus.pix_valid, 0);
        check("pwm_no_beat", beats.size(), 0);

        // ---- 2: window 790..799 x 470..479, 101 pixels ----
        mcu_write(1'b0, 16'h0003); mcu_write(1'b1, 16'd790);
        mcu_write(1'b0, 16'h0007); mcu_write(1'b1, 16'd799);
        mcu_write(1'b0, 16'h0002); mcu_write(1'b1, 16'd470);
        mcu_write(1'b0, 16'h0006); mcu_write(1'b1, 16'd479);
        bus.pix_ready = 1'b1;
        mcu_write(1'b0, 16'h000F);
        for (int i = 0; i < 101; i++) mcu_write(1'b1, 16'h001F + 16'(i));
        check("scan_count", beats.size(), 101);
        if (beats.size() == 101) begin
            for (int i = 0; i < 101; i++) begin
                check("scan_data", beats[i].d, 32'h1F + i);
                check("scan_x", beats[i].x, 790 + (i % 10));
                check("scan_y", beats[i].y, 470 + ((i / 10) % 10));
                check("scan_sof", beats[i].sof, (i % 100) == 0);
            end
        end

        // ---- 3: backpressure and overflow ----
        bus.pix_ready = 1'b0;
        mcu_write(1'b1, 16'hAAAA);
        check("bp_valid", bus.pix_valid, 1);
        check("bp_data", bus.pix_data, 16'hAAAA);
        check("bp_xy", {bus.pix_x, bus.pix_y}, {10'd791, 9'd470});
        check("bp_sof", bus.pix_sof, 0);
        check("bp_ovf0", overflow, 0);
        mcu_write(1'b1, 16'hBBBB);
        check("ovf_held_data", bus.pix_data, 16'hAAAA);
        check("ovf_held_x", bus.pix_x, 791);
        check("ovf_set", overflow, 1);
        drain_one();
        check("drain_valid", bus.pix_valid, 0);
        mcu_write(1'b0, 16'h0010);
        check("ovf_clear", overflow, 0);
        mcu_write(1'b1, 16'h1234);
        check("not_streaming", bus.pix_valid, 0);

        // ---- 4: clamp and collapsed window ----
        mcu_write(1'b0, 16'h0003); mcu_write(1'b1, 16'd900);
        mcu_write(1'b0, 16'h0006); mcu_write(1'b1, 16'd0);
        mcu_write(1'b0, 16'h0002); mcu_write(1'b1, 16'd5);
        beats.delete();
        bus.pix_ready = 1'b1;
        mcu_write(1'b0, 16'h000F);
        for (int i = 0; i < 3; i++) mcu_write(1'b1, 16'h0100 + 16'(i));
        bus.pix_ready = 1'b0;
        check("clamp_count", beats.size(), 3);
        if (beats.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("clamp_data", beats[i].d, 32'h100 + i);
                check("clamp_x", beats[i].x, 799);
                check("clamp_y", beats[i].y, 5);
                check("clamp_sof", beats[i].sof, 1);
            end
        end

        // ---- 5: reset mid-stream ----
        mcu_write(1'b0, 16'h000F);
        mcu_write(1'b1, 16'h0055);
        check("pre_rst_valid", bus.pix_valid, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rst_async_valid", bus.pix_valid, 0);
        check("rst_pwm_default", pwm_duty, 0);
        @(negedge clk);
        rst = 1'b0;
        mcu_write(1'b1, 16'h0066);
        check("post_rst_ignored", bus.pix_valid, 0);
        mcu_write(1'b0, 16'h000F);
        mcu_write(1'b1, 16'h0077);
        check("post_rst_valid", bus.pix_valid, 1);
        check("post_rst_xy", {bus.pix_x, bus.pix_y}, 0);
        check("post_rst_sof", bus.pix_sof, 1);
        check("post_rst_data", bus.pix_data, 16'h0077);
        drain_one();
        mcu_write(1'b1, 16'h0078);
        check("post_rst_x1", bus.pix_x, 1);
        check("post_rst_sof1", bus.pix_sof, 0);
        drain_one();

        // ---- 6: readback ----
        mcu_write(1'b0, 16'h0007);
        mcu_write(1'b1, 16'd799);
        @(negedge clk);
        bus.mcu_cs_n = 1'b0;
        bus.mcu_rs   = 1'b1;
        bus.mcu_rd_n = 1'b0;
        repeat (4) @(negedge clk);
`ifdef MCU_READBACK_EN
        check("rb_oe", bus.mcu_data_oe, 1);
        check("rb_data", bus.mcu_data_out, 799);
`else
        check("rb_oe_off", bus.mcu_data_oe, 0);
        check("rb_data_off", bus.mcu_data_out, 0);
`endif
        bus.mcu_rd_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rb_oe_drop", bus.mcu_data_oe, 0);
        bus.mcu_cs_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
